uart_tx_fifo: RTL and testbench

Parametrised second-generation UART transmitter. It buffers words in an internal FIFO and serialises them LSB-first onto a single line, with runtime-selectable baud divisor, parity mode and stop-bit count. It sits between any valid/ready byte producer (CPU bridge, DMA, packetiser) and the board TX pin. It replaces the fixed 8N1, single-buffer transmitter for new designs.

---
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal word FIFO, runtime baud divisor,
// selectable parity (none/even/odd) and one or two stop bits.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic [DIV_WIDTH-1:0]                 cfg_div,
    input  logic [1:0]                           cfg_parity,
    input  logic                                 cfg_stop2,
    output logic                                 tx_sig,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [DIV_WIDTH-1:0]   timer;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_clamped;
    logic [BW-1:0]          bit_cnt;
    logic                   par_en;
    logic                   par_bit;
    logic                   stop2_q;
    logic                   stop_second;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   bit_end;
    logic                   stop_done;

    // Ready is decoded from the level register only, never from a same-cycle pop.
    assign in_ready    = (fifo_level != LW'(FIFO_DEPTH));
    assign push        = in_valid && in_ready;
    assign fifo_empty  = (fifo_level == '0);
    assign bit_end     = (timer == '0);
    assign stop_done   = (state == S_STOP) && bit_end && (!stop2_q || stop_second);
    assign pop         = !fifo_empty && ((state == S_IDLE) || stop_done);
    assign div_clamped = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            tx_sig      <= 1'b1;
            busy        <= 1'b0;
            shreg       <= '0;
            timer       <= '0;
            div_q       <= '0;
            bit_cnt     <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2_q     <= 1'b0;
            stop_second <= 1'b0;
        end else if (pop) begin
            // Frame start from IDLE or straight out of the last stop cycle.
            state       <= S_START;
            shreg       <= mem[rd_ptr];
            par_bit     <= (^mem[rd_ptr]) ^ (cfg_parity == 2'b10);
            par_en      <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            stop2_q     <= cfg_stop2;
            div_q       <= div_clamped;
            timer       <= div_clamped - 1'b1;
            bit_cnt     <= '0;
            stop_second <= 1'b0;
            tx_sig      <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_sig <= 1'b1;
                    busy   <= 1'b0;
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        timer   <= div_q - 1'b1;
                        bit_cnt <= '0;
                        tx_sig  <= shreg[0];
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer <= div_q - 1'b1;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            if (par_en) begin
                                state  <= S_PARITY;
                                tx_sig <= par_bit;
                            end else begin
                                state       <= S_STOP;
                                stop_second <= 1'b0;
                                tx_sig      <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx_sig  <= shreg[1];
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state       <= S_STOP;
                        timer       <= div_q - 1'b1;
                        stop_second <= 1'b0;
                        tx_sig      <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_done) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        tx_sig <= 1'b1;
                    end else if (bit_end) begin
                        stop_second <= 1'b1;
                        timer       <= div_q - 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    tx_sig <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes every frame and
// compares it against a queue of expected words filled at each handshake.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic [DIVW-1:0] cfg_div = 16'd4;
    logic [1:0]      cfg_parity = 2'b00;
    logic            cfg_stop2 = 1'b0;
    logic            tx_sig;
    logic            busy;
    logic [2:0]      fifo_level;

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_sig     (tx_sig),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            div;
        bit            par_en;
        bit            odd;
        bit            stop2;
    } exp_t;

    exp_t exp_q[$];
    int   start_times[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   frames_done = 0;
    int   idle_err = 0;

    bit   mon_active = 0;
    exp_t cur;
    logic exp_bits [20];
    int   nbits, mon_bit, mon_cyc, frame_idx = 0;
    bit   mon_ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Line monitor: samples on the falling edge, one expected level per bit time.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_active = 0;
        end else begin
            if (!mon_active && tx_sig === 1'b0) begin
                check($sformatf("frame%0d_expected", frame_idx), exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    exp_bits[0] = 1'b0;
                    for (int b = 0; b < DW; b++) exp_bits[1 + b] = cur.data[b];
                    nbits = 1 + DW;
                    if (cur.par_en) begin
                        exp_bits[nbits] = (^cur.data) ^ cur.odd;
                        nbits++;
                    end
                    exp_bits[nbits] = 1'b1;
                    nbits++;
                    if (cur.stop2) begin
                        exp_bits[nbits] = 1'b1;
                        nbits++;
                    end
                    start_times.push_back(cyc);
                    mon_active = 1;
                    mon_bit    = 0;
                    mon_cyc    = 0;
                    mon_ok     = 1;
                end
            end else if (!mon_active && busy !== 1'b0) begin
                idle_err++;
            end
            if (mon_active) begin
                if (tx_sig !== exp_bits[mon_bit] || busy !== 1'b1) mon_ok = 0;
                mon_cyc++;
                if (mon_cyc == cur.div) begin
                    check($sformatf("frame%0d_bit%0d", frame_idx, mon_bit), mon_ok, 1);
                    mon_bit++;
                    mon_cyc = 0;
                    mon_ok  = 1;
                    if (mon_bit == nbits) begin
                        mon_active = 0;
                        frame_idx++;
                        frames_done++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input int ediv, input logic [1:0] epar, input bit es2);
        exp_t e;
        e.data   = d;
        e.div    = ediv;
        e.par_en = (epar == 2'b01) || (epar == 2'b10);
        e.odd    = (epar == 2'b10);
        e.stop2  = es2;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [DW-1:0] d, input int ediv, input logic [1:0] epar, input bit es2);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 5000 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("push_accepted", acc, 1);
        if (acc) expect_word(d, ediv, epar, es2);
    endtask

    task automatic busy_len(input string tag, input int expv);
        int w = 0;
        int n = 0;
        while (busy !== 1'b1 && w < 5000) begin
            tick();
            w++;
        end
        while (busy === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check(tag, n, expv);
    endtask

    task automatic wait_frames(input int target);
        int w = 0;
        while (frames_done < target && w < 5000) begin
            tick();
            w++;
        end
        check("frames_done", frames_done, target);
    endtask

    logic [DW-1:0] words [10];

    initial begin
        int base;
        int acc_cnt;
        int first_block;
        int started;
        logic [2:0] prev_level;
        bit rdy;

        words = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A, 8'hC6, 8'h12, 8'h9E, 8'h47, 8'hB3};

        // Reset
        tick(5);
        check("in_reset_tx_sig", tx_sig, 1);
        check("in_reset_busy", busy, 0);
        rstn = 1'b1;
        tick();
        check("rst_tx_sig", tx_sig, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 1);
        tick(10);
        check("idle_tx_sig", tx_sig, 1);
        check("idle_busy", busy, 0);

        // 8N1 frame and first-word latency
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push_word(8'hA5, 4, 2'b00, 0);
        check("lat_level_one", fifo_level, 1);
        check("lat_tx_still_idle", tx_sig, 1);
        check("lat_busy_still_low", busy, 0);
        tick();
        check("lat_tx_start", tx_sig, 0);
        check("lat_busy_high", busy, 1);
        check("lat_level_zero", fifo_level, 0);
        busy_len("len_8n1", 40);
        wait_frames(1);

        // Parity with two stop bits
        cfg_div = 16'd8; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        push_word(8'h07, 8, 2'b01, 1);
        busy_len("len_even_2stop", 96);
        wait_frames(2);
        cfg_parity = 2'b10;
        push_word(8'h07, 8, 2'b10, 1);
        busy_len("len_odd_2stop", 96);
        wait_frames(3);

        // FIFO fill with back-to-back frames
        cfg_div = 16'd16; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        base        = start_times.size();
        acc_cnt     = 0;
        first_block = -1;
        in_valid    = 1'b1;
        in_data     = words[0];
        for (int i = 0; i < 5000 && acc_cnt < 10; i++) begin
            rdy        = in_ready;
            prev_level = fifo_level;
            tick();
            if (rdy) begin
                expect_word(words[acc_cnt], 16, 2'b00, 0);
                acc_cnt++;
                if (acc_cnt < 10) in_data = words[acc_cnt];
            end
            if (!in_ready && first_block < 0) first_block = acc_cnt;
            if (prev_level == 3'd4 && fifo_level == 3'd3) check("ready_after_pop", in_ready, 1);
        end
        in_valid = 1'b0;
        check("fill_accept_count", acc_cnt, 10);
        check("accepted_before_full", first_block, 5);
        wait_frames(13);
        if (start_times.size() >= base + 10) begin
            for (int k = 1; k < 10; k++)
                check($sformatf("b2b_gap%0d", k), start_times[base + k] - start_times[base + k - 1], 160);
        end else begin
            check("fill_frame_count", start_times.size() - base, 10);
        end

        // Divisor change during the first frame's data bits
        cfg_div = 16'd4;
        base = start_times.size();
        push_word(8'h5A, 4, 2'b00, 0);
        push_word(8'hC3, 8, 2'b00, 0);
        tick(6);
        cfg_div = 16'd8;
        busy_len("len_cfg_change_rest", 40 + 80 - 6);
        wait_frames(15);
        if (start_times.size() >= base + 2)
            check("cfg_frame1_len", start_times[base + 1] - start_times[base], 40);
        else
            check("cfg_frame_count", start_times.size() - base, 2);

        // Asynchronous reset during the third data bit
        cfg_div = 16'd4;
        push_word(8'h11, 4, 2'b00, 0);
        push_word(8'h22, 4, 2'b00, 0);
        push_word(8'h33, 4, 2'b00, 0);
        tick(12);
        check("pre_reset_level", fifo_level, 2);
        check("pre_reset_busy", busy, 1);
        started = start_times.size();
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_tx_sig", tx_sig, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_level", fifo_level, 0);
        check("async_rst_in_ready", in_ready, 1);
        exp_q.delete();
        tick(3);
        rstn = 1'b1;
        tick(100);
        check("post_rst_no_frames", start_times.size(), started);
        check("post_rst_tx_sig", tx_sig, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_level", fifo_level, 0);
        check("idle_busy_violations", idle_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
